// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the instruction issue sequencer.
package ctrl_seq_pkg;

    localparam int unsigned INSTR_W         = 16;
    localparam int unsigned DEFAULT_DEPTH   = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 4;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StSrc,
        StExec,
        StWait,
        StHalt
    } seq_state_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Host and control-unit signals of the issue sequencer, bundled in one interface.
interface ctrl_sequencer_if #(
    parameter int unsigned DEPTH = ctrl_seq_pkg::DEFAULT_DEPTH
);
    import ctrl_seq_pkg::*;

    logic                 push_valid;
    logic [INSTR_W-1:0]   push_data;
    logic                 push_ready;
    logic                 run;
    logic                 stall;
    logic                 err_clear;
    logic [INSTR_W-1:0]   cu_instruction;
    logic                 cu_en_i;
    logic                 cu_en_s;
    logic                 cu_en_c;
    logic                 cu_done;
    logic [INSTR_W-1:0]   cu_d_out;
    logic                 result_valid;
    logic [INSTR_W-1:0]   result_data;
    logic                 busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0]          retired;
    logic                 timeout_err;

    // Host plus control unit: drives requests and the unit's done/result.
    modport master (
        output push_valid, push_data, run, stall, err_clear, cu_done, cu_d_out,
        input  push_ready, cu_instruction, cu_en_i, cu_en_s, cu_en_c,
        input  result_valid, result_data, busy, fifo_count, retired, timeout_err
    );

    // Sequencer side.
    modport slave (
        input  push_valid, push_data, run, stall, err_clear, cu_done, cu_d_out,
        output push_ready, cu_instruction, cu_en_i, cu_en_s, cu_en_c,
        output result_valid, result_data, busy, fifo_count, retired, timeout_err
    );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO; head always shows the storage at the read pointer.
module instr_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO rejects pushes even when a pop happens on the same edge.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer/count next state; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Issue sequencer: feeds queued instructions to the control unit one at a time.
module ctrl_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input logic             clk,
    input logic             reset,
    ctrl_sequencer_if.slave seq_io
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    seq_state_t         state_q;
    logic [WAIT_W-1:0]  wait_q;
    logic               result_valid_q;
    logic [INSTR_W-1:0] result_data_q;
    logic [15:0]        retired_q;
    logic               timeout_err_q;

    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [INSTR_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (seq_io.push_valid),
        .push_data_i (seq_io.push_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // The instruction-load strobe doubles as the FIFO pop.
    assign fifo_pop = (state_q == StIssue) && !seq_io.stall;

    assign seq_io.cu_en_i        = fifo_pop;
    assign seq_io.cu_en_s        = (state_q == StSrc) && !seq_io.stall;
    assign seq_io.cu_en_c        = (state_q == StExec) && !seq_io.stall;
    assign seq_io.cu_instruction = fifo_head;
    assign seq_io.push_ready     = !fifo_full;
    assign seq_io.fifo_count     = fifo_count;
    assign seq_io.result_valid   = result_valid_q;
    assign seq_io.result_data    = result_data_q;
    assign seq_io.retired        = retired_q;
    assign seq_io.timeout_err    = timeout_err_q;
    assign seq_io.busy           = (state_q != StIdle);

    // Sequencing FSM with result capture, retire count and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            wait_q         <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            retired_q      <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (seq_io.err_clear) begin
                timeout_err_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (!seq_io.stall && seq_io.run && !fifo_empty) begin
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (!seq_io.stall) begin
                        state_q <= StSrc;
                    end
                end
                StSrc: begin
                    if (!seq_io.stall) begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (!seq_io.stall) begin
                        state_q <= StWait;
                        wait_q  <= '0;
                    end
                end
                // stall has no effect here; the unit is already computing.
                StWait: begin
                    if (seq_io.cu_done) begin
                        result_data_q  <= seq_io.cu_d_out;
                        result_valid_q <= 1'b1;
                        retired_q      <= retired_q + 16'd1;
                        state_q        <= (seq_io.run && !fifo_empty) ? StIssue : StIdle;
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_q       <= StHalt;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                StHalt: begin
                    if (seq_io.err_clear) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer with a control-unit stub that returns ~instruction.
module tb_ctrl_sequencer;
    import ctrl_seq_pkg::*;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ctrl_sequencer_if #(.DEPTH(DEPTH)) ifc ();

    ctrl_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .seq_io (ifc)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: expected results in issue order and retire count.
    logic [15:0] exp_q[$];
    logic [15:0] retired_m = 16'd0;

    // Control-unit stub: done two cycles after the calc strobe, result = ~instruction.
    logic [15:0] stub_cap;
    int          stub_ph;
    bit          stub_hang = 1'b0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stub_ph      <= 0;
            stub_cap     <= '0;
            ifc.cu_done  <= 1'b0;
            ifc.cu_d_out <= '0;
        end else begin
            if (ifc.cu_en_i) stub_cap <= ifc.cu_instruction;
            ifc.cu_done <= 1'b0;
            if (ifc.cu_en_c) begin
                stub_ph <= 1;
            end else if (stub_ph == 1) begin
                stub_ph <= 0;
                if (!stub_hang) begin
                    ifc.cu_done  <= 1'b1;
                    ifc.cu_d_out <= ~stub_cap;
                end
            end
        end
    end

    // Monitor: cycle count, result log, strobe exclusivity.
    int          cyc = 0;
    int          res_cyc[$];
    logic [15:0] res_val[$];
    int          overlap = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ifc.result_valid === 1'b1) begin
            res_val.push_back(ifc.result_data);
            res_cyc.push_back(cyc);
        end
        if (int'(ifc.cu_en_i) + int'(ifc.cu_en_s) + int'(ifc.cu_en_c) > 1) overlap <= overlap + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        ifc.push_valid = 1'b1;
        ifc.push_data  = w;
        step();
        ifc.push_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifc.push_valid = 1'b0;
        ifc.push_data  = '0;
        ifc.run        = 1'b0;
        ifc.stall      = 1'b0;
        ifc.err_clear  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (ifc.push_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_push_ready: got %b want 1", ifc.push_ready);
        end
        vectors++;
        if (ifc.cu_instruction !== 16'h0) begin
            miscompares++; $display("FAIL reset_instr: got %h want 0000", ifc.cu_instruction);
        end
        vectors++;
        if ({ifc.cu_en_i, ifc.cu_en_s, ifc.cu_en_c} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b%b%b want 000", ifc.cu_en_i, ifc.cu_en_s, ifc.cu_en_c);
        end
        vectors++;
        if ({ifc.result_valid, ifc.busy, ifc.timeout_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got rv=%b busy=%b terr=%b want 0", ifc.result_valid, ifc.busy,
                     ifc.timeout_err);
        end
        vectors++;
        if (ifc.result_data !== 16'h0 || ifc.retired !== 16'h0 || ifc.fifo_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_values: got data=%h retired=%0d count=%0d want 0", ifc.result_data,
                     ifc.retired, ifc.fifo_count);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        ifc.run = 1'b1;
        res_val.delete(); res_cyc.delete();
        push_word(16'h1234);
        exp_q.push_back(~16'h1234);
        vectors++;
        if (ifc.fifo_count !== 4'd1 || ifc.cu_en_i !== 1'b0) begin
            miscompares++;
            $display("FAIL single_after_push: got count=%0d en_i=%b want 1/0", ifc.fifo_count, ifc.cu_en_i);
        end
        step();
        vectors++;
        if (ifc.cu_en_i !== 1'b1 || ifc.cu_instruction !== 16'h1234) begin
            miscompares++;
            $display("FAIL single_issue: got en_i=%b instr=%h want 1/1234", ifc.cu_en_i, ifc.cu_instruction);
        end
        step();
        vectors++;
        if ({ifc.cu_en_i, ifc.cu_en_s, ifc.cu_en_c} !== 3'b010) begin
            miscompares++; $display("FAIL single_src: got %b%b%b want 010", ifc.cu_en_i, ifc.cu_en_s, ifc.cu_en_c);
        end
        step();
        vectors++;
        if ({ifc.cu_en_i, ifc.cu_en_s, ifc.cu_en_c} !== 3'b001) begin
            miscompares++; $display("FAIL single_exec: got %b%b%b want 001", ifc.cu_en_i, ifc.cu_en_s, ifc.cu_en_c);
        end
        step();
        step();
        vectors++;
        if (ifc.cu_done !== 1'b1 || ifc.result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done_cycle: got done=%b rv=%b want 1/0", ifc.cu_done, ifc.result_valid);
        end
        step();
        void'(exp_q.pop_front());
        retired_m++;
        vectors++;
        if (ifc.result_valid !== 1'b1 || ifc.result_data !== 16'hEDCB || ifc.retired !== retired_m) begin
            miscompares++;
            $display("FAIL single_result: got rv=%b data=%h retired=%0d want 1/edcb/%0d", ifc.result_valid,
                     ifc.result_data, ifc.retired, retired_m);
        end
        step();
        vectors++;
        if (ifc.result_valid !== 1'b0 || ifc.result_data !== 16'hEDCB || ifc.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_after: got rv=%b data=%h busy=%b want 0/edcb/0", ifc.result_valid,
                     ifc.result_data, ifc.busy);
        end
    endtask

    task automatic test_fill_drain();
        logic [15:0] w;
        int n;
        ifc.run = 1'b0;
        for (int i = 0; i < int'(DEPTH) + 1; i++) begin
            w = 16'($urandom);
            if (i == int'(DEPTH)) begin
                vectors++;
                if (ifc.push_ready !== 1'b0) begin
                    miscompares++; $display("FAIL fill_ready_full: got %b want 0", ifc.push_ready);
                end
            end
            if (exp_q.size() < int'(DEPTH)) exp_q.push_back(~w);
            push_word(w);
        end
        vectors++;
        if (ifc.fifo_count !== 4'(DEPTH)) begin
            miscompares++; $display("FAIL fill_count: got %0d want %0d", ifc.fifo_count, DEPTH);
        end
        res_val.delete(); res_cyc.delete();
        ifc.run = 1'b1;
        n = 0;
        while (res_val.size() < int'(DEPTH) && n < 80) begin step(); n++; end
        vectors++;
        if (res_val.size() != int'(DEPTH)) begin
            miscompares++; $display("FAIL fill_drain_count: got %0d results want %0d", res_val.size(), DEPTH);
        end
        for (int i = 0; i < res_val.size(); i++) begin
            vectors++;
            if (res_val[i] !== exp_q[0]) begin
                miscompares++; $display("FAIL fill_order[%0d]: got %h want %h", i, res_val[i], exp_q[0]);
            end
            void'(exp_q.pop_front());
            retired_m++;
            if (i > 0) begin
                vectors++;
                if (res_cyc[i] - res_cyc[i-1] != 5) begin
                    miscompares++;
                    $display("FAIL fill_spacing[%0d]: got %0d cycles want 5", i, res_cyc[i] - res_cyc[i-1]);
                end
            end
        end
        step();
        vectors++;
        if (ifc.retired !== retired_m || ifc.push_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_retired: got %0d ready=%b want %0d/1", ifc.retired, ifc.push_ready, retired_m);
        end
    endtask

    task automatic test_stall();
        logic [15:0] w;
        int n;
        w = 16'($urandom);
        ifc.run = 1'b1;
        push_word(w);
        n = 0;
        while (ifc.cu_en_s !== 1'b1 && n < 10) begin step(); n++; end
        vectors++;
        if (ifc.cu_en_s !== 1'b1) begin
            miscompares++; $display("FAIL stall_reach_src: got en_s=%b want 1", ifc.cu_en_s);
        end
        step();
        ifc.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (ifc.cu_en_c !== 1'b0 || dut.state_q !== StExec) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got en_c=%b state=%0d want 0/%0d", k, ifc.cu_en_c,
                         dut.state_q, StExec);
            end
            step();
        end
        ifc.stall = 1'b0;
        #1;
        vectors++;
        if (ifc.cu_en_c !== 1'b1) begin
            miscompares++; $display("FAIL stall_release: got en_c=%b want 1", ifc.cu_en_c);
        end
        step();
        step();
        vectors++;
        if (ifc.result_valid !== 1'b0) begin
            miscompares++; $display("FAIL stall_early: got rv=%b want 0", ifc.result_valid);
        end
        step();
        retired_m++;
        vectors++;
        if (ifc.result_valid !== 1'b1 || ifc.result_data !== ~w) begin
            miscompares++;
            $display("FAIL stall_result: got rv=%b data=%h want 1/%h", ifc.result_valid, ifc.result_data, ~w);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] w;
        int n;
        bit issued;
        stub_hang = 1'b1;
        ifc.run = 1'b1;
        push_word(16'($urandom));
        n = 0;
        while (ifc.cu_en_c !== 1'b1 && n < 10) begin step(); n++; end
        repeat (TIMEOUT) step();
        vectors++;
        if (ifc.timeout_err !== 1'b0 || dut.state_q !== StWait) begin
            miscompares++;
            $display("FAIL timeout_early: got terr=%b state=%0d want 0/%0d", ifc.timeout_err, dut.state_q, StWait);
        end
        step();
        vectors++;
        if (ifc.timeout_err !== 1'b1 || dut.state_q !== StHalt || ifc.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_halt: got terr=%b state=%0d busy=%b want 1/%0d/1", ifc.timeout_err,
                     dut.state_q, ifc.busy, StHalt);
        end
        w = 16'($urandom);
        push_word(w);
        issued = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (ifc.cu_en_i === 1'b1) issued = 1'b1;
            step();
        end
        vectors++;
        if (issued || ifc.fifo_count !== 4'd1) begin
            miscompares++;
            $display("FAIL timeout_no_issue: got issued=%b count=%0d want 0/1", issued, ifc.fifo_count);
        end
        stub_hang = 1'b0;
        ifc.err_clear = 1'b1;
        step();
        ifc.err_clear = 1'b0;
        vectors++;
        if (ifc.timeout_err !== 1'b0 || ifc.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear: got terr=%b busy=%b want 0/0", ifc.timeout_err, ifc.busy);
        end
        res_val.delete(); res_cyc.delete();
        n = 0;
        while (res_val.size() < 1 && n < 12) begin step(); n++; end
        retired_m++;
        vectors++;
        if (res_val.size() != 1 || ifc.retired !== retired_m) begin
            miscompares++;
            $display("FAIL timeout_resume: got %0d results retired=%0d want 1/%0d", res_val.size(),
                     ifc.retired, retired_m);
        end else if (res_val[0] !== ~w) begin
            miscompares++; $display("FAIL timeout_resume_data: got %h want %h", res_val[0], ~w);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        ifc.run = 1'b0;
        for (int i = 0; i < 4; i++) push_word(16'($urandom));
        ifc.run = 1'b1;
        n = 0;
        while (ifc.cu_en_s !== 1'b1 && n < 10) begin step(); n++; end
        vectors++;
        if (ifc.fifo_count !== 4'd3) begin
            miscompares++; $display("FAIL rstmid_queued: got %0d want 3", ifc.fifo_count);
        end
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        retired_m = 16'd0;
        vectors++;
        if ({ifc.cu_en_i, ifc.cu_en_s, ifc.cu_en_c, ifc.busy} !== 4'b0000 || ifc.fifo_count !== 4'd0) begin
            miscompares++;
            $display("FAIL rstmid_state: got en_s=%b busy=%b count=%0d want 0/0/0", ifc.cu_en_s, ifc.busy,
                     ifc.fifo_count);
        end
        vectors++;
        if (ifc.retired !== retired_m || ifc.cu_instruction !== 16'h0 || ifc.push_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_values: got retired=%0d instr=%h ready=%b want 0/0000/1", ifc.retired,
                     ifc.cu_instruction, ifc.push_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_run_drop();
        logic [15:0] w[3];
        int n;
        bit issued;
        ifc.run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w[i] = 16'($urandom);
            push_word(w[i]);
        end
        ifc.run = 1'b1;
        n = 0;
        while (ifc.cu_en_c !== 1'b1 && n < 10) begin step(); n++; end
        step();
        ifc.run = 1'b0;
        step();
        step();
        retired_m++;
        vectors++;
        if (ifc.result_valid !== 1'b1 || ifc.result_data !== ~w[0]) begin
            miscompares++;
            $display("FAIL rundrop_result: got rv=%b data=%h want 1/%h", ifc.result_valid, ifc.result_data, ~w[0]);
        end
        vectors++;
        if (ifc.busy !== 1'b0 || ifc.fifo_count !== 4'd2) begin
            miscompares++;
            $display("FAIL rundrop_idle: got busy=%b count=%0d want 0/2", ifc.busy, ifc.fifo_count);
        end
        issued = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (ifc.cu_en_i === 1'b1) issued = 1'b1;
        end
        vectors++;
        if (issued) begin
            miscompares++; $display("FAIL rundrop_hold: got issue while run=0 want none");
        end
        res_val.delete(); res_cyc.delete();
        ifc.run = 1'b1;
        n = 0;
        while (res_val.size() < 2 && n < 20) begin step(); n++; end
        vectors++;
        if (res_val.size() != 2) begin
            miscompares++; $display("FAIL rundrop_resume: got %0d results want 2", res_val.size());
        end else if (res_val[0] !== ~w[1] || res_val[1] !== ~w[2]) begin
            miscompares++;
            $display("FAIL rundrop_resume_data: got %h %h want %h %h", res_val[0], res_val[1], ~w[1], ~w[2]);
        end
        retired_m += 16'd2;
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        int pushed;
        int n;
        res_val.delete(); res_cyc.delete();
        exp_q.delete();
        pushed = 0;
        for (int i = 0; i < 120; i++) begin
            ifc.run   = ($urandom_range(0, 9) != 0);
            ifc.stall = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1 && (pushed - res_val.size()) < int'(DEPTH)) begin
                w = 16'($urandom);
                vectors++;
                if (ifc.push_ready !== 1'b1) begin
                    miscompares++; $display("FAIL b2b_ready[%0d]: got 0 want 1", i);
                end
                exp_q.push_back(~w);
                pushed++;
                push_word(w);
            end else begin
                step();
            end
        end
        ifc.run = 1'b1;
        ifc.stall = 1'b0;
        n = 0;
        while (res_val.size() < pushed && n < 400) begin step(); n++; end
        step();
        vectors++;
        if (res_val.size() != pushed) begin
            miscompares++; $display("FAIL b2b_count: got %0d results want %0d", res_val.size(), pushed);
        end
        for (int i = 0; i < res_val.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (res_val[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", i, res_val[i], exp_q[i]);
            end
        end
        retired_m += 16'(pushed);
        vectors++;
        if (ifc.retired !== retired_m || ifc.fifo_count !== 4'd0 || ifc.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_final: got retired=%0d count=%0d busy=%b want %0d/0/0", ifc.retired,
                     ifc.fifo_count, ifc.busy, retired_m);
        end
        vectors++;
        if (overlap != 0) begin
            miscompares++; $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_run_drop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Issue sequencer for the register-file/ALU control unit. It buffers 16-bit instructions pushed by a host in an internal FIFO and drives the control unit's instruction and enable strobes (load instruction, load source, commit calc) one instruction at a time. It waits for the unit's done pulse, then returns the result to the host. It sits between the host/test driver and the control unit and shares that unit's clock and reset.

## Interface
Parameters:
- DEPTH, 8: instruction FIFO entries; power of two, minimum 2.
- TIMEOUT, 4: cycles allowed in WAIT for cu_done before error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- push_valid  in  1  host offers an instruction.
- push_data  in  16  instruction word.
- push_ready  out  1  equals !full.
- run  in  1  level; when low, no new instruction is issued and any in-flight instruction completes.
- stall  in  1  while high, no enable strobe is asserted and the FSM holds its state.
- err_clear  in  1  clears timeout_err and leaves HALT.
- cu_instruction  out  16  FIFO head word.
- cu_en_i  out  1  instruction-load strobe.
- cu_en_s  out  1  source-load strobe.
- cu_en_c  out  1  calc-commit strobe.
- cu_done  in  1  control unit done pulse.
- cu_d_out  in  16  control unit result.
- result_valid  out  1  one-cycle pulse.
- result_data  out  16  captured result; holds until the next capture.
- busy  out  1  FSM not in IDLE.
- fifo_count  out  $clog2(DEPTH)+1  current number of FIFO entries.
- retired  out  16  completed-instruction counter; wraps 0xFFFF→0.
- timeout_err  out  1  sticky error flag.

## Operation
- FSM states: IDLE, ISSUE, SRC, EXEC, WAIT, HALT.
- **IDLE**
  - Goes to ISSUE when run=1 and the FIFO is non-empty.
- **ISSUE**
  - cu_en_i = !stall.
  - When cu_en_i is asserted, the FIFO pops at the clock edge and the FSM goes to SRC.
  - Stall holds the FSM in ISSUE with no pop.
- **SRC**
  - cu_en_s = !stall.
  - Goes to EXEC when the strobe is asserted.
- **EXEC**
  - cu_en_c = !stall.
  - Goes to WAIT when the strobe is asserted.
- **WAIT**
  - Runs a wait counter.
  - On cu_done: capture cu_d_out into result_data, pulse result_valid next cycle, increment retired.
  - Next state after cu_done: ISSUE if run=1 and the FIFO is non-empty, otherwise IDLE.
  - If the wait counter reaches TIMEOUT without cu_done: go to HALT and set timeout_err.
  - stall is ignored in WAIT.
- **HALT**
  - No strobes.
  - The FIFO keeps accepting pushes.
  - err_clear → IDLE and clears timeout_err.
- Strobe rules:
  - Strobes are combinational from the state and stall.
  - At most one strobe is high in any cycle.
- FIFO push rules:
  - A push is accepted when push_valid && push_ready.
  - Simultaneous push and pop when full: the push is rejected (push_ready=0).
  - When empty: a pop is impossible, so push only.
  - Pointers wrap modulo DEPTH.
- cu_instruction always equals the FIFO head storage, including stale data when the FIFO is empty.
- run falling during SRC, EXEC or WAIT does not abort the in-flight instruction.

## Timing
- Reset values:
  - FSM in IDLE, FIFO empty, all storage 0.
  - push_ready=1; cu_instruction=0; all strobes 0.
  - result_valid=0, result_data=0, busy=0, fifo_count=0, retired=0, timeout_err=0.
- Nominal instruction, with ISSUE at cycle t:
  - SRC at t+1, EXEC at t+2.
  - WAIT at t+3 (control unit in STORE).
  - cu_done at t+4.
  - result_valid at t+5; back-to-back ISSUE also at t+5.
  - Throughput: 5 cycles per instruction.
- Push-to-issue latency from IDLE: a push at edge e gives fifo_count=1 after e; ISSUE begins the cycle after that.
- fifo_count updates the cycle after the push/pop edge.
- Reset mid-instruction: everything returns to reset values immediately, asynchronously. The control unit shares the reset, so no partial instruction survives.

## Structure
- Package ctrl_seq_pkg:
  - state enum (seq_state_t).
  - INSTR_W=16, default DEPTH and TIMEOUT constants.
- One sub-module, instr_fifo:
  - Synchronous FIFO parameterised by DEPTH and width.
  - Async reset; push/pop/full/empty/count.
- The FSM, strobes, counters and result capture live in ctrl_sequencer.

## Test plan
Bench uses a control unit stub that follows the unit's strobe protocol and returns cu_d_out = ~instruction on its done cycle.
- Push 16'h1234 with run=1 → en_i/en_s/en_c on consecutive cycles, cu_done at t+4, result_valid at t+5 with result_data=16'hEDCB, retired=1.
- Push 8 words, then a 9th → push_ready=0 after the 8th, 9th rejected, fifo_count=8. With run=1, 8 results in order at 5-cycle spacing.
- Assert stall for 3 cycles during EXEC → cu_en_c low for those cycles, FSM stays in EXEC, result delayed exactly 3 cycles, value unchanged.
- Stub never asserts done → after 4 WAIT cycles FSM enters HALT, timeout_err=1, no further issues. Pulse err_clear → IDLE, timeout_err=0.
- Reset asserted during SRC with 3 entries queued → outputs return to reset values in the same cycle, fifo_count=0, retired=0.
- Drop run while in WAIT with 2 entries queued → current result delivered, FSM returns to IDLE, fifo_count=2. Raise run → issue resumes.
